mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous memory.
// Fetch and data ports share one memory access per cycle. Data wins by
// default. Fetch wins once it has been starved for STARVE_MAX cycles.
// Read data returns one cycle after the grant and is steered to its owner.
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [15:0]       conflict_cnt
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t          r_owner;
  logic [SW-1:0]   r_starveCnt;
  logic [15:0]     r_conflictCnt;

  logic            w_ifWins;
  logic            w_ifGnt;
  logic            w_dGnt;
  logic            w_store;
  logic            w_ifRvalid;
  logic            w_dRvalid;

  // Grant decision: data first, unless fetch has waited STARVE_MAX cycles.
  // Grants are suppressed entirely while reset is held low.
  always_comb begin
    w_ifWins = if_req && (!d_req || (r_starveCnt == STARVE_LIM));
    w_ifGnt  = reset && w_ifWins;
    w_dGnt   = reset && d_req && !w_ifWins;
    w_store  = w_dGnt && d_we;
  end

  // Memory controls follow whichever requester holds the grant this cycle.
  always_comb begin
    mem_en    = w_ifGnt || w_dGnt;
    mem_we    = w_store;
    mem_be    = w_store ? d_be : 4'b0000;
    mem_wdata = w_store ? d_wdata : 32'd0;
    if (w_dGnt) begin
      mem_addr = d_addr;
    end else if (w_ifGnt) begin
      mem_addr = if_addr;
    end else begin
      mem_addr = '0;
    end
  end

  // Read data from the previous cycle's access goes to its owner only;
  // a flush in the return cycle suppresses fetch data.
  always_comb begin
    w_ifRvalid = reset && (r_owner == OWN_IF) && !if_flush;
    w_dRvalid  = reset && (r_owner == OWN_D);
    if_rvalid  = w_ifRvalid;
    d_rvalid   = w_dRvalid;
    if_rdata   = w_ifRvalid ? mem_rdata : 32'd0;
    d_rdata    = w_dRvalid ? mem_rdata : 32'd0;
  end

  assign if_gnt       = w_ifGnt;
  assign d_gnt        = w_dGnt;
  assign conflict_cnt = r_conflictCnt;

  // Read-owner state: remembers who is due read data next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_NONE;
    end else if (w_ifGnt && !if_flush) begin
      r_owner <= OWN_IF;
    end else if (w_dGnt && !d_we) begin
      r_owner <= OWN_D;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  // Starvation counter: counts consecutive denied fetch cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starveCnt <= '0;
    end else if (if_req && !w_ifGnt) begin
      if (r_starveCnt != STARVE_LIM) begin
        r_starveCnt <= r_starveCnt + 1'b1;
      end
    end else begin
      r_starveCnt <= '0;
    end
  end

  // Saturating count of cycles where both ports are requesting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conflictCnt <= 16'd0;
    end else if (if_req && d_req && (r_conflictCnt != 16'hFFFF)) begin
      r_conflictCnt <= r_conflictCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a reference arbitration model
// predicts grants each cycle and queues the expected read returns.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 10;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              reset;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [15:0]       conflict_cnt;

  typedef struct {
    logic        ifValid;
    logic [31:0] ifData;
    logic        dValid;
    logic [31:0] dData;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] memArr [0:(1<<ADDR_W)-1];
  logic [31:0] refMem [0:(1<<ADDR_W)-1];
  int          mStarve;
  int          mConflict;
  logic        lastIfGnt;
  logic        lastDGnt;
  int          assertCount;
  int          failCount;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port synchronous memory driven by the DUT's controls.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) memArr[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= memArr[mem_addr];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " gnts"}, {30'd0, if_gnt, d_gnt}, 32'd0);
    checkOutput({tag, " mem_en/we"}, {30'd0, mem_en, mem_we}, 32'd0);
    checkOutput({tag, " rvalids"}, {30'd0, if_rvalid, d_rvalid}, 32'd0);
    checkOutput({tag, " if_rdata"}, if_rdata, 32'd0);
    checkOutput({tag, " d_rdata"}, d_rdata, 32'd0);
    checkOutput({tag, " conflict_cnt"}, {16'd0, conflict_cnt}, 32'd0);
  endtask

  function automatic exp_t noneExp();
    exp_t e;
    e.ifValid = 1'b0; e.ifData = 32'd0; e.dValid = 1'b0; e.dData = 32'd0;
    return e;
  endfunction

  // One cycle: drive inputs, check returns and grants at the falling edge,
  // advance the reference model and queue next cycle's expected returns.
  task automatic applyStimulus(input logic ifReq, input logic [ADDR_W-1:0] ifAddr,
                               input logic ifFlush, input logic dReq, input logic dWe,
                               input logic [3:0] dBe, input logic [ADDR_W-1:0] dAddr,
                               input logic [31:0] dWdata);
    exp_t e;
    exp_t nx;
    logic eIf;
    logic eD;
    logic eStore;
    if_req = ifReq; if_addr = ifAddr; if_flush = ifFlush;
    d_req = dReq; d_we = dWe; d_be = dBe; d_addr = dAddr; d_wdata = dWdata;
    @(negedge clk);
    if (expQ.size() == 0) begin
      failCount++;
      assertCount++;
      $display("[TB] FAIL scoreboard: observed empty queue expected entry");
      e = noneExp();
    end else begin
      e = expQ.pop_front();
    end
    checkOutput("if_rvalid", {31'd0, if_rvalid}, {31'd0, e.ifValid && !ifFlush});
    checkOutput("if_rdata", if_rdata, (e.ifValid && !ifFlush) ? e.ifData : 32'd0);
    checkOutput("d_rvalid", {31'd0, d_rvalid}, {31'd0, e.dValid});
    checkOutput("d_rdata", d_rdata, e.dValid ? e.dData : 32'd0);
    checkOutput("conflict_cnt", {16'd0, conflict_cnt}, mConflict);
    eIf    = ifReq && (!dReq || mStarve == STARVE_MAX);
    eD     = dReq && !eIf;
    eStore = eD && dWe;
    checkOutput("if_gnt", {31'd0, if_gnt}, {31'd0, eIf});
    checkOutput("d_gnt", {31'd0, d_gnt}, {31'd0, eD});
    checkOutput("mem_en", {31'd0, mem_en}, {31'd0, eIf || eD});
    checkOutput("mem_we", {31'd0, mem_we}, {31'd0, eStore});
    checkOutput("mem_be", {28'd0, mem_be}, eStore ? {28'd0, dBe} : 32'd0);
    checkOutput("mem_wdata", mem_wdata, eStore ? dWdata : 32'd0);
    if (eIf || eD) checkOutput("mem_addr", {22'd0, mem_addr}, eD ? {22'd0, dAddr} : {22'd0, ifAddr});
    nx.ifValid = eIf && !ifFlush;
    nx.ifData  = refMem[ifAddr];
    nx.dValid  = eD && !dWe;
    nx.dData   = refMem[dAddr];
    expQ.push_back(nx);
    if (eStore) begin
      for (int b = 0; b < 4; b++) begin
        if (dBe[b]) refMem[dAddr][8*b +: 8] = dWdata[8*b +: 8];
      end
    end
    if (ifReq && !eIf) mStarve = (mStarve < STARVE_MAX) ? mStarve + 1 : STARVE_MAX;
    else mStarve = 0;
    if (ifReq && dReq && mConflict < 65535) mConflict++;
    lastIfGnt = eIf;
    lastDGnt  = eD;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'd0);
  endtask

  initial begin
    logic              rIfReq;
    logic [ADDR_W-1:0] rIfAddr;
    logic              rDReq;
    logic              rDWe;
    logic [3:0]        rDBe;
    logic [ADDR_W-1:0] rDAddr;
    logic [31:0]       rDWdata;
    assertCount = 0;
    failCount   = 0;
    mStarve     = 0;
    mConflict   = 0;
    lastIfGnt   = 1'b0;
    lastDGnt    = 1'b0;
    mem_rdata   = 32'd0;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      memArr[i] = (i * 32'h01010101) ^ 32'hA5A50000;
      refMem[i] = memArr[i];
    end
    memArr[0] = 32'h00100093; refMem[0] = 32'h00100093;
    memArr[1] = 32'h00200113; refMem[1] = 32'h00200113;
    memArr[2] = 32'h00000000; refMem[2] = 32'h00000000;
    memArr[7] = 32'h11223344; refMem[7] = 32'h11223344;

    // Reset held with both ports requesting: everything must stay quiet.
    reset = 1'b0;
    if_req = 1'b1; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 10'd5; d_wdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;
    expQ.push_back(noneExp());

    // Fetch-only stream, addresses 0,1,2, then drain.
    for (int a = 0; a < 3; a++) applyStimulus(1'b1, 10'(a), 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'd0);
    repeat (2) idleCycle();

    // Both requesting continuously: 4 data grants then one fetch grant.
    for (int c = 0; c < 10; c++) applyStimulus(1'b1, 10'd9, 1'b0, 1'b1, 1'b0, 4'h0, 10'd5, 32'd0);
    idleCycle();

    // Partial store then read-back of the merged word.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b1, 4'b0011, 10'd7, 32'hDEADBEEF);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'h0, 10'd7, 32'd0);
    idleCycle();

    // Flush in the grant cycle, then a load that must still return.
    applyStimulus(1'b1, 10'd3, 1'b1, 1'b0, 1'b0, 4'h0, '0, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'h0, 10'd5, 32'd0);
    idleCycle();

    // Flush in the return cycle suppresses the fetch data.
    applyStimulus(1'b1, 10'd1, 1'b0, 1'b0, 1'b0, 4'h0, '0, 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0, 4'h0, '0, 32'd0);
    idleCycle();

    // Random traffic; a denied request is held until granted.
    rIfReq = 1'b0; rIfAddr = '0; rDReq = 1'b0; rDWe = 1'b0;
    rDBe = 4'h0; rDAddr = '0; rDWdata = 32'd0;
    for (int n = 0; n < 40; n++) begin
      if (!(rIfReq && !lastIfGnt)) begin
        rIfReq  = 1'($urandom_range(0, 1));
        rIfAddr = 10'($urandom_range(0, 15));
      end
      if (!(rDReq && !lastDGnt)) begin
        rDReq   = 1'($urandom_range(0, 1));
        rDWe    = 1'($urandom_range(0, 1));
        rDBe    = 4'($urandom_range(0, 15));
        rDAddr  = 10'($urandom_range(0, 15));
        rDWdata = $urandom;
      end
      applyStimulus(rIfReq, rIfAddr, 1'($urandom_range(0, 3) == 0), rDReq, rDWe, rDBe, rDAddr, rDWdata);
    end
    idleCycle();

    // Reset asserted in the cycle after a load grant: its data is dropped.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0, 4'h0, 10'd5, 32'd0);
    reset = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
    @(negedge clk);
    checkResetOutputs("midreset");
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("midreset2");
    expQ.delete();
    mStarve   = 0;
    mConflict = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    expQ.push_back(noneExp());
    repeat (2) idleCycle();

    // Long dual-request run saturates the conflict counter.
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_flush = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    checkOutput("conflict_sat", {16'd0, conflict_cnt}, 32'h0000FFFF);
    if_req = 1'b1; d_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("conflict_hold", {16'd0, conflict_cnt}, 32'h0000FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
